// File: rtl/isp_boot_pkg.sv
// ============================================================================
// Module   : isp_boot_pkg
// Purpose  : Shared state encoding and stream-format constants for the ISP boot controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package isp_boot_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_HDR   = 3'd1,
      S_ENTRY = 3'd2,
      S_LOAD  = 3'd3,
      S_CHK   = 3'd4,
      S_START = 3'd5,
      S_RUN   = 3'd6,
      S_ERROR = 3'd7
   } state_e;

   // The header count field spans [ADDRESS_BITS:0] so it can express 2^ADDRESS_BITS itself.
   localparam int unsigned HDR_CNT_LSB  = 0;
   localparam int unsigned ENTRY_ADDR_W = 20;

   function automatic int unsigned hdr_cnt_msb(input int unsigned address_bits);
      return address_bits;
   endfunction

endpackage

`default_nettype wire

// File: rtl/isp_checksum_acc.sv
// ============================================================================
// Module   : isp_checksum_acc
// Purpose  : Modular running sum of payload words with an equality compare.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module isp_checksum_acc #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  clear_i,
   input  logic                  add_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic [DATA_WIDTH-1:0] cmp_data_i,
   output logic                  match_o
);

   logic [DATA_WIDTH-1:0] sum_q;

   always_ff @(posedge clock) begin
      if (reset || clear_i) begin
         sum_q <= '0;
      end else if (add_i) begin
         sum_q <= sum_q + data_i;
      end
   end

   assign match_o = (cmp_data_i == sum_q);

endmodule

`default_nettype wire

// File: rtl/isp_boot_controller.sv
// ============================================================================
// Module   : isp_boot_controller
// Purpose  : Streams a program image into core memory via ISP, then releases the core
//            and pulses start. Optional trailing checksum: define ISP_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module isp_boot_controller
   import isp_boot_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDRESS_BITS = 12
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    boot_req,
   input  logic [DATA_WIDTH-1:0]   in_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic                    core_reset,
   output logic                    start,
   output logic [ENTRY_ADDR_W-1:0] prog_address,
   output logic                    isp_write,
   output logic [ADDRESS_BITS-1:0] isp_address,
   output logic [DATA_WIDTH-1:0]   isp_data,
   output logic                    busy,
   output logic                    done,
   output logic                    error
);

   localparam int CNT_W   = ADDRESS_BITS + 1;
   localparam int CNT_MSB = int'(hdr_cnt_msb(ADDRESS_BITS));
   localparam logic [CNT_W-1:0] N_MAX = {1'b1, {ADDRESS_BITS{1'b0}}};

`ifdef ISP_CHECKSUM_EN
   localparam state_e AFTER_PAYLOAD = S_CHK;
`else
   localparam state_e AFTER_PAYLOAD = S_START;
`endif

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        n_q, n_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [ENTRY_ADDR_W-1:0] entry_q, entry_d;
   logic [ENTRY_ADDR_W-1:0] prog_address_q;
   logic                    start_q;
   logic                    core_reset_q;
   logic                    isp_write_q;
   logic [ADDRESS_BITS-1:0] isp_address_q;
   logic [DATA_WIDTH-1:0]   isp_data_q;

   logic                    w_xfer;
   logic                    w_load_xfer;
   logic [CNT_W-1:0]        w_hdr_n;
   logic                    w_last;

   assign in_ready = (state_q inside {S_HDR, S_ENTRY, S_LOAD, S_CHK});
   assign w_xfer   = in_valid && in_ready;
   assign w_hdr_n  = in_data[CNT_MSB:HDR_CNT_LSB];
   assign w_last   = ((cnt_q + CNT_W'(1)) == n_q);

`ifdef ISP_CHECKSUM_EN
   logic w_sum_match;

   isp_checksum_acc #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_checksum (
      .clock      (clock),
      .reset      (reset),
      .clear_i    (state_q == S_HDR),
      .add_i      (w_load_xfer),
      .data_i     (in_data),
      .cmp_data_i (in_data),
      .match_o    (w_sum_match)
   );
`endif

   always_comb begin
      state_d     = state_q;
      n_d         = n_q;
      cnt_d       = cnt_q;
      entry_d     = entry_q;
      w_load_xfer = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (boot_req) state_d = S_HDR;
         end
         S_HDR: begin
            if (w_xfer) begin
               if (w_hdr_n > N_MAX) begin
                  state_d = S_ERROR;
               end else begin
                  n_d     = w_hdr_n;
                  cnt_d   = '0;
                  state_d = S_ENTRY;
               end
            end
         end
         S_ENTRY: begin
            if (w_xfer) begin
               entry_d = in_data[ENTRY_ADDR_W-1:0];
               state_d = (n_q != '0) ? S_LOAD : AFTER_PAYLOAD;
            end
         end
         S_LOAD: begin
            if (w_xfer) begin
               w_load_xfer = 1'b1;
               cnt_d       = cnt_q + CNT_W'(1);
               if (w_last) state_d = AFTER_PAYLOAD;
            end
         end
`ifdef ISP_CHECKSUM_EN
         S_CHK: begin
            if (w_xfer) state_d = w_sum_match ? S_START : S_ERROR;
         end
`endif
         S_START: begin
            state_d = S_RUN;
         end
         S_RUN, S_ERROR: begin
            if (boot_req) state_d = S_HDR;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // start/core_reset are registered off the state so the pulse trails the last ISP write by one cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= S_IDLE;
         n_q            <= '0;
         cnt_q          <= '0;
         entry_q        <= '0;
         prog_address_q <= '0;
         start_q        <= 1'b0;
         core_reset_q   <= 1'b1;
         isp_write_q    <= 1'b0;
         isp_address_q  <= '0;
         isp_data_q     <= '0;
      end else begin
         state_q      <= state_d;
         n_q          <= n_d;
         cnt_q        <= cnt_d;
         entry_q      <= entry_d;
         start_q      <= (state_q == S_START);
         core_reset_q <= !((state_q == S_START) || (state_q == S_RUN));
         isp_write_q  <= w_load_xfer;
         if (state_q == S_START) prog_address_q <= entry_q;
         if (w_load_xfer) begin
            isp_address_q <= cnt_q[ADDRESS_BITS-1:0];
            isp_data_q    <= in_data;
         end
      end
   end

   assign core_reset   = core_reset_q;
   assign start        = start_q;
   assign prog_address = prog_address_q;
   assign isp_write    = isp_write_q;
   assign isp_address  = isp_address_q;
   assign isp_data     = isp_data_q;
   assign busy         = (state_q inside {S_HDR, S_ENTRY, S_LOAD, S_CHK, S_START});
   assign done         = (state_q == S_RUN);
   assign error        = (state_q == S_ERROR);

endmodule

`default_nettype wire
